// File: rtl/iter_divider_32.sv
// ============================================================================
// Module   : iter_divider_32
// Brief    : Restoring RV32M divider (DIV/DIVU/REM/REMU) on a shared add/sub unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module iter_divider_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WIDTH-1);

    state_t           state_q;
    logic             rem_sel_q;
    logic             sign_quo_q;
    logic             sign_rem_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             is_signed;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] shift_rem;
    logic             take;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fix_res;
    logic             in_calc;

    // op[0]=1 selects the unsigned variants; op[1]=1 selects remainder.
    assign is_signed = ~op[0];
    assign dvd_neg   = is_signed & dividend[WIDTH-1];
    assign dvs_neg   = is_signed & divisor[WIDTH-1];
    assign abs_dvd   = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign abs_dvs   = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed && (dividend == C_MIN_NEG) && (divisor == '1);

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? dividend : '1;
        else
            special_res = op[1] ? '0 : C_MIN_NEG;
    end

    // The partial remainder can reach 33 bits; rem_q[MSB] is that hidden bit,
    // and when set the trial subtraction always succeeds.
    assign shift_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign take      = rem_q[WIDTH-1] | add_cout;
    assign rem_d     = take ? add_sum : shift_rem;
    assign quo_d     = {quo_q[WIDTH-2:0], take};

    assign quo_fix = sign_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
    assign rem_fix = sign_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
    assign fix_res = rem_sel_q ? rem_fix : quo_fix;

    assign in_calc = (state_q == S_CALC);
    assign add_x   = in_calc ? shift_rem : '0;
    assign add_y   = in_calc ? dvsr_q : '0;
    assign add_sub = in_calc;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rem_sel_q  <= 1'b0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start && !kill) begin
                        rem_sel_q  <= op[1];
                        sign_quo_q <= dvd_neg ^ dvs_neg;
                        sign_rem_q <= dvd_neg;
                        dvsr_q     <= abs_dvs;
                        if (div_zero || ovf) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= abs_dvd;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == C_LAST)
                            state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iter_divider_32.sv
// ============================================================================
// Module   : tb_iter_divider_32
// Brief    : Scoreboard bench for iter_divider_32 with a behavioural add/sub unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iter_divider_32;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_sub;
    logic [31:0] add_sum;
    logic        add_cout;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    logic [31:0] last_exp = 32'h0;
    exp_t sb[$];

    iter_divider_32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .kill     (kill),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .add_x    (add_x),
        .add_y    (add_y),
        .add_sub  (add_sub),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Shared carry-lookahead add/sub unit stand-in: x + (sub ? ~y : y) + sub
    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
                                 + {32'h0, add_sub};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        if (b == 32'h0) return o[1] ? a : 32'hFFFFFFFF;
        if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return o[1] ? 32'h0 : 32'h80000000;
        case (o)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // Done is observed mid-cycle; cyc+1 is the edge at which it is sampled.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_edge", 32'(cyc + 1), 32'(e.due));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        exp_t        e;
        bit          sp;
        logic [31:0] abs_b;
        sp    = (b == 32'h0) || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        abs_b = (!o[0] && b[31]) ? (32'h0 - b) : b;
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        last_acc = cyc;
        e.res    = model(o, a, b);
        e.due    = cyc + (sp ? 1 : 34);
        if (push) begin
            sb.push_back(e);
            last_exp = e.res;
        end
        chk("busy_after_accept", 32'(busy), 32'(!sp));
        chk("add_sub", 32'(add_sub), 32'(!sp));
        if (!sp) chk("add_y", add_y, abs_b);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc + 1 < last_acc + n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00;
        dividend = 32'h0; divisor = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_add_x", add_x, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 32'd100, 32'd7, 1'b1);               wait_done(60); @(negedge clk);
        issue(2'b11, 32'd100, 32'd7, 1'b1);               wait_done(60); @(negedge clk);
        issue(2'b00, 32'hFFFFFFF9, 32'd2, 1'b1);          wait_done(60); @(negedge clk);
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b1);          wait_done(60); @(negedge clk);
        issue(2'b01, 32'hFFFFFFFF, 32'h80000001, 1'b1);   wait_done(60); @(negedge clk);
        issue(2'b11, 32'hFFFFFFFF, 32'h80000001, 1'b1);   wait_done(60); @(negedge clk);
        issue(2'b01, 32'd5, 32'd0, 1'b1);                 wait_done(60); @(negedge clk);
        issue(2'b10, 32'd5, 32'd0, 1'b1);                 wait_done(60); @(negedge clk);
        issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 1'b1);   wait_done(60); @(negedge clk);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1);   wait_done(60); @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 31);
            issue(ro, ra, rb, 1'b1); wait_done(60); @(negedge clk);
        end

        // Flush mid-operation, then a fresh start the very next cycle.
        issue(2'b01, 32'd1000, 32'd3, 1'b0);
        wait_edge(10);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_done", 32'(done), 32'd0);
        chk("kill_result", result, last_exp);
        issue(2'b00, 32'hFFFFFF9C, 32'd7, 1'b1);          wait_done(60); @(negedge clk);

        // Reset in the middle of a computation.
        issue(2'b01, 32'd12345, 32'd11, 1'b0);
        wait_edge(20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_add", {add_x[30:0] | add_y[30:0], add_sub}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b11, 32'd12345, 32'd11, 1'b1);            wait_done(60); @(negedge clk);

        // start held high: second accept lands one cycle after the done pulse.
        begin
            exp_t e;
            op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
            @(posedge clk);
            #1;
            e.res = 32'd333;  e.due = cyc + 34;      sb.push_back(e);
            e.res = 32'd155;  e.due = cyc + 35 + 34; sb.push_back(e);
            dividend = 32'd777; divisor = 32'd5;
            chk("b2b_busy", 32'(busy), 32'd1);
            wait_done(100);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("b2b_no_third", 32'(busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
